// File: rtl/button_events.sv
// button_events: turns a debounced, clk-synchronous button level into
// single-cycle event pulses (press, release, click, double click, long press,
// optional auto-repeat) plus a busy flag.
//
// Optional feature: define BUTTON_EVENTS_REPEAT_EN to build the auto-repeat
// logic. Without it repeat_pulse is tied low and count holds while in LONG.
//
// "release" and "repeat" are SystemVerilog keywords, so those two pulses are
// named release_pulse and repeat_pulse.
module button_events #(
  parameter int unsigned LONG_LIMIT   = 12000000,
  parameter int unsigned DOUBLE_LIMIT = 3600000,
  parameter int unsigned REPEAT_LIMIT = 1200000,
  parameter int          CNT_SIZE     = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_in,
  output logic press,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG,
    WAIT2,
    PRESSED2
  } state_t;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  // Terminal counts: a timed state fires when count reaches limit-1.
  localparam logic [CNT_SIZE-1:0] LONG_END   = CNT_SIZE'(LONG_LIMIT - 1);
  localparam logic [CNT_SIZE-1:0] DOUBLE_END = CNT_SIZE'(DOUBLE_LIMIT - 1);
  localparam logic [CNT_SIZE-1:0] REPEAT_END = CNT_SIZE'(REPEAT_LIMIT - 1);
  localparam logic [CNT_SIZE-1:0] CNT_ONE    = CNT_SIZE'(1);

  state_t              state_q, state_d;
  logic [CNT_SIZE-1:0] count_q, count_d;
  logic                press_d, release_d, click_d, double_d, long_d, repeat_d;

  // Next-state, next-count and next-pulse decode; switch_in takes priority
  // over every timeout so a release/press on the limit edge wins.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (switch_in) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end

      PRESSED: begin
        count_d = count_q + CNT_ONE;
        if (!switch_in) begin
          state_d   = WAIT2;
          release_d = 1'b1;
        end else if (count_q == LONG_END) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end

      LONG: begin
        if (!switch_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (REPEAT_EN) begin
          // Repeat restarts the period without leaving the state.
          if (count_q == REPEAT_END) begin
            repeat_d = 1'b1;
            count_d  = '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end

      WAIT2: begin
        count_d = count_q + CNT_ONE;
        if (switch_in) begin
          state_d = PRESSED2;
          press_d = 1'b1;
        end else if (count_q == DOUBLE_END) begin
          state_d = IDLE;
          click_d = 1'b1;
        end
      end

      PRESSED2: begin
        count_d = count_q + CNT_ONE;
        if (!switch_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (count_q == LONG_END) begin
          // Held too long: the pending double click is dropped.
          state_d = LONG;
          long_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Every state change starts the new state's timer from zero.
    if (state_d != state_q) count_d = '0;
  end

  // State, counter and registered outputs; reset aborts any gesture silently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the same pre-edge values.
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      press         <= press_d;
      release_pulse <= release_d;
      click         <= click_d;
      double_click  <= double_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      busy          <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed gestures followed by random hold/gap runs, each
// cycle compared against a timestamp-based model of the event rules.
module tb_button_events;

  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 4;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit MODEL_REPEAT = 1'b1;
`else
  localparam bit MODEL_REPEAT = 1'b0;
`endif

  logic clk;
  logic reset;
  logic switch_in;
  logic press, release_pulse, click, double_click, long_press, repeat_pulse, busy;

  int total = 0;
  int bad   = 0;

  // Model: gesture bookkeeping by elapsed time since the last marker event.
  int t            = 0;
  bit in_gesture   = 0;
  bit held         = 0;
  bit long_mode    = 0;
  bit second_press = 0;
  int t_mark       = 0;

  button_events #(
    .LONG_LIMIT  (L),
    .DOUBLE_LIMIT(D),
    .REPEAT_LIMIT(R),
    .CNT_SIZE    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .switch_in    (switch_in),
    .press        (press),
    .release_pulse(release_pulse),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic sw, input logic rst);
    bit e_press, e_rel, e_click, e_dbl, e_long, e_rep;
    switch_in = sw;
    reset     = rst;
    @(posedge clk);
    #1;
    t++;
    {e_press, e_rel, e_click, e_dbl, e_long, e_rep} = '0;
    if (rst) begin
      in_gesture = 0;
      held       = 0;
      long_mode  = 0;
    end else if (!in_gesture) begin
      if (sw) begin
        e_press      = 1;
        in_gesture   = 1;
        held         = 1;
        long_mode    = 0;
        second_press = 0;
        t_mark       = t;
      end
    end else if (held) begin
      if (!sw) begin
        e_rel = 1;
        held  = 0;
        if (long_mode) begin
          in_gesture = 0;
        end else if (second_press) begin
          e_dbl      = 1;
          in_gesture = 0;
        end else begin
          t_mark = t;
        end
      end else if (!long_mode && (t - t_mark == L)) begin
        e_long    = 1;
        long_mode = 1;
        t_mark    = t;
      end else if (long_mode && MODEL_REPEAT && (t - t_mark == R)) begin
        e_rep  = 1;
        t_mark = t;
      end
    end else begin
      if (sw) begin
        e_press      = 1;
        held         = 1;
        second_press = 1;
        t_mark       = t;
      end else if (t - t_mark == D) begin
        e_click    = 1;
        in_gesture = 0;
      end
    end
    check("press",        press,         e_press);
    check("release",      release_pulse, e_rel);
    check("click",        click,         e_click);
    check("double_click", double_click,  e_dbl);
    check("long_press",   long_press,    e_long);
    check("repeat",       repeat_pulse,  e_rep);
    check("busy",         busy,          in_gesture);
  endtask

  task automatic hold(input logic sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b0);
  endtask

  initial begin
    logic sw;
    switch_in = 1'b0;
    reset     = 1'b1;

    // Reset with the button up, then a press one cycle later.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    hold(1'b1, 1);
    hold(1'b0, 14);

    // Single click.
    hold(1'b1, 5); hold(1'b0, 14);
    // Double click.
    hold(1'b1, 5); hold(1'b0, 4); hold(1'b1, 5); hold(1'b0, 3);
    // Long press with repeats.
    hold(1'b1, 35); hold(1'b0, 3);
    // Release on the long-limit edge, then the click timeout.
    hold(1'b1, 20); hold(1'b0, 12);
    // Second press on the WAIT2 timeout edge, then a double click.
    hold(1'b1, 5); hold(1'b0, 10); hold(1'b1, 3); hold(1'b0, 3);
    // Second press held to the long limit abandons the double click.
    hold(1'b1, 4); hold(1'b0, 2); hold(1'b1, 27); hold(1'b0, 3);
    // Reset during WAIT2.
    hold(1'b1, 3); hold(1'b0, 3);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    hold(1'b0, 15);
    // Button already down when reset deasserts.
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    hold(1'b1, 3); hold(1'b0, 14);

    // Random hold/gap runs with occasional resets.
    sw = 1'b0;
    for (int run = 0; run < 150; run++) begin
      sw = ~sw;
      if ($urandom_range(0, 24) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(sw, 1'b1);
      end
      hold(sw, int'($urandom_range(1, 28)));
    end
    hold(1'b0, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
